placement_overlap_checker: RTL and testbench
============================================

# placement_overlap_checker

Streaming geometry checker that sits directly downstream of the netlist placement parser. It consumes one placed box per handshake (instance id plus x/y origin decoded from the instance name) and compares each new box against every box already received for the current module. It emits one report per overlapping pair and pulses `done` at the end of each module, feeding the overlap-highlight stage of the visualizer.

## Interface
- `COORD_W`, 16: unsigned width of x/y coordinates.
- `ID_W`, 8: instance id width.
- `DEPTH`, 16: maximum boxes stored per module; must be a power of two.
- `BOX_W`, 80: box width in coordinate units; constant for all boxes.
- `BOX_H`, 80: box height in coordinate units; constant for all boxes.

- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  box placement valid.
- `in_ready`  out  1  block accepts a box.
- `in_id`  in  ID_W  instance id.
- `in_x`, `in_y`  in  COORD_W  box origin.
- `in_last`  in  1  marks the last box of the module.
- `out_valid`  out  1  overlap report valid.
- `out_ready`  in  1  consumer accepts the report.
- `out_id_a`  out  ID_W  id of the older, stored box.
- `out_id_b`  out  ID_W  id of the newly received box.
- `done`  out  1  one-cycle pulse at the end of a module.
- `overflow`  out  1  sticky flag: a box arrived while the table was full; cleared at `done`.
- `overlap_count`  out  16  overlap pairs found in the current module.

## Operation
- States:
  - `IDLE`: `in_ready`=1.
  - `SCAN`: compares the new box with table entry `i`, one entry per cycle, oldest first.
  - `EMIT`: holds a report until it is accepted.
  - `STORE`: writes the new box into the table.
  - `FIN`: pulses `done` and clears state.
- Transitions:
  - `IDLE` + `in_valid` → latch the box; go to `SCAN` with `i`=0, or to `STORE` if the table is empty.
  - `SCAN`, entry `i` overlaps → `EMIT`.
  - `SCAN`, no overlap at `i` → `i+1`; when `i`=count-1, go to `STORE`.
  - `EMIT` + `out_ready` → resume `SCAN` at `i+1`, or go to `STORE` if `i` was the last entry.
  - `STORE` → `FIN` if the latched `in_last`=1, else `IDLE`.
  - `FIN` → `IDLE`.
- Overlap test, with `dx` = |x_new − x_old| and `dy` = |y_new − y_old| computed as signed `COORD_W`+1 differences: overlap iff `dx` < `BOX_W` AND `dy` < `BOX_H`. Strict comparison, so boxes that exactly abut (`dx`=80) do not overlap.
- Table full (count=`DEPTH`) when a box arrives: the box is still scanned and reported, but not stored; `overflow` is set.
- `FIN` resets count to 0 and clears `overflow` and `overlap_count` one cycle after the `done` pulse.
- Duplicate ids are not checked; they are compared like any other box.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` is low, 1 in the first cycle after release (`IDLE`).
  - `out_valid`, `done`, `overflow` = 0.
  - `out_id_a`, `out_id_b` = 0.
  - `overlap_count` = 0.
  - Table count = 0.
- Per-box latency with k stored entries and no backpressure: 1 accept cycle + k `SCAN` cycles + 1 per reported overlap + 1 `STORE` cycle.
- `done` asserts in the cycle after `STORE` of the last box and lasts exactly one cycle.
- `out_valid` rises the cycle after the matching `SCAN` compare. `out_id_a`/`out_id_b` are stable while `out_valid`=1 and `out_ready`=0. The report completes on the cycle where both are high.
- `overlap_count` increments in the cycle the report handshake completes; it saturates at 0xFFFF.
- Asynchronous reset mid-scan or mid-emit:
  - Outputs drop immediately.
  - The table is cleared.
  - A pending report is lost.

## Configuration
- `OVERLAP_COUNT_EN` defined: the 16-bit counter and `overlap_count` behave as above.
- Not defined: the counter is not built; `overlap_count` is tied to 0. All other behaviour is identical.

## Test plan
- Boxes (1,0,0), (2,0,40, last) → one report a=1, b=2; `done` pulses; count=1.
- Boxes (1,0,0), (2,40,0, last) → one report a=1, b=2.
- Boxes (1,0,0), (2,0,80), (3,80,0), (4,80,80, last) → no reports; `done` pulses; count=0.
- Boxes (1,0,0), (2,0,40), (3,0,80, last) → reports (1,2) then (2,3), never (1,3); count=2. With `out_ready` held low for 5 cycles, the ids stay stable throughout.
- Boxes (1,0,0), (2,0,40), (3,120,120, last) → exactly one report (1,2).
- `DEPTH`=16: 17 non-overlapping boxes → `overflow`=1 before `done`, then 0. Separately, `rst_n` pulsed low during `EMIT` → `out_valid`=0 immediately; a following module starts with an empty table.

Source files
------------

// File: rtl/placement_overlap_checker.sv
// Streaming box-overlap checker: each new placed box is compared against every stored box of the current module.
// Optional feature macro: OVERLAP_COUNT_EN builds the saturating overlap_count counter (otherwise tied to 0).
module placement_overlap_checker #(
  parameter int COORD_W = 16,
  parameter int ID_W    = 8,
  parameter int DEPTH   = 16,
  parameter int BOX_W   = 80,
  parameter int BOX_H   = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ID_W-1:0]    in_id,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    out_id_a,
  output logic [ID_W-1:0]    out_id_b,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        overlap_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]      ONE  = CW'(1);
  localparam logic [CW-1:0]      FULL = CW'(DEPTH);
  localparam logic [COORD_W:0]   BW   = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0]   BH   = (COORD_W+1)'(BOX_H);

  typedef enum logic [2:0] {IDLE, SCAN, EMIT, STORE, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [ID_W-1:0]   ida_q, ida_d;
  logic [ID_W-1:0]   idb_q, idb_d;

  logic [ID_W-1:0]    nid_q;
  logic [COORD_W-1:0] nx_q, ny_q;
  logic               nlast_q;

  logic [ID_W-1:0]    id_mem [DEPTH];
  logic [COORD_W-1:0] x_mem  [DEPTH];
  logic [COORD_W-1:0] y_mem  [DEPTH];

  logic [ID_W-1:0]    rd_id;
  logic [COORD_W-1:0] rd_x, rd_y;
  logic               hit, last_entry, wr_en;

  // Exact |a-b| using a one-bit-wider signed difference so coordinates never wrap.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[COORD_W]) return -d;
    return d;
  endfunction

  assign rd_id      = id_mem[idx_q[AW-1:0]];
  assign rd_x       = x_mem[idx_q[AW-1:0]];
  assign rd_y       = y_mem[idx_q[AW-1:0]];
  assign hit        = (abs_diff(nx_q, rd_x) < BW) && (abs_diff(ny_q, rd_y) < BH);
  assign last_entry = (idx_q == count_q - ONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    ida_d   = ida_q;
    idb_d   = idb_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d = '0;
          if (count_q == FULL) ovf_d = 1'b1;
          state_d = (count_q == '0) ? STORE : SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          ida_d   = rd_id;
          idb_d   = nid_q;
          state_d = EMIT;
        end else if (last_entry) begin
          state_d = STORE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_entry) begin
            state_d = STORE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = SCAN;
          end
        end
      end
      STORE: begin
        // A full table still lets the box be scanned; it is simply not retained.
        if (count_q != FULL) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE;
        end
        state_d = nlast_q ? FIN : IDLE;
      end
      FIN: begin
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      ida_q   <= '0;
      idb_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      ida_q   <= ida_d;
      idb_q   <= idb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      nid_q   <= in_id;
      nx_q    <= in_x;
      ny_q    <= in_y;
      nlast_q <= in_last;
    end
    if (wr_en) begin
      id_mem[count_q[AW-1:0]] <= nid_q;
      x_mem[count_q[AW-1:0]]  <= nx_q;
      y_mem[count_q[AW-1:0]]  <= ny_q;
    end
  end

`ifdef OVERLAP_COUNT_EN
  logic [15:0] ocnt_q, ocnt_d;

  always_comb begin
    ocnt_d = ocnt_q;
    if (state_q == FIN) ocnt_d = '0;
    else if (state_q == EMIT && out_ready && ocnt_q != 16'hFFFF) ocnt_d = ocnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ocnt_q <= '0;
    else        ocnt_q <= ocnt_d;
  end

  assign overlap_count = ocnt_q;
`else
  assign overlap_count = 16'd0;
`endif

  // Held low during reset even though the state register already sits in IDLE.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign done      = (state_q == FIN);
  assign overflow  = ovf_q;
  assign out_id_a  = ida_q;
  assign out_id_b  = idb_q;

endmodule

// File: tb/tb_placement_overlap_checker.sv
// Scoreboard bench for placement_overlap_checker: a box-list reference model predicts reports and end-of-module status.
module tb_placement_overlap_checker;
  localparam int COORD_W = 16;
  localparam int ID_W    = 8;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ID_W-1:0]    in_id = '0;
  logic [COORD_W-1:0] in_x = '0;
  logic [COORD_W-1:0] in_y = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [ID_W-1:0]    out_id_a;
  logic [ID_W-1:0]    out_id_b;
  logic               done;
  logic               overflow;
  logic [15:0]        overlap_count;

  placement_overlap_checker #(
    .COORD_W(COORD_W), .ID_W(ID_W), .DEPTH(DEPTH), .BOX_W(80), .BOX_H(80)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id_a(out_id_a), .out_id_b(out_id_b),
    .done(done), .overflow(overflow), .overlap_count(overlap_count)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int x; int y; } box_t;
  typedef struct { int a; int b; } rep_t;
  typedef struct { int ovf; int cnt; } fin_t;

  box_t tbl[$];
  rep_t exp_q[$];
  fin_t fin_q[$];
  int   m_ovf = 0;
  int   m_cnt = 0;

  int vectors = 0;
  int errors  = 0;
  bit stall_en = 1'b0;
  bit rnd_en   = 1'b0;

  function automatic void check(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: a module is a list of stored boxes; a new box pairs with every stored one it overlaps.
  function automatic void model_box(int id, int x, int y, bit last);
    for (int i = 0; i < tbl.size(); i++) begin
      if (iabs(x - tbl[i].x) < 80 && iabs(y - tbl[i].y) < 80) begin
        exp_q.push_back('{tbl[i].id, id});
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (tbl.size() == DEPTH) m_ovf = 1;
    else tbl.push_back('{id, x, y});
    if (last) begin
`ifdef OVERLAP_COUNT_EN
      fin_q.push_back('{m_ovf, m_cnt});
`else
      fin_q.push_back('{m_ovf, 0});
`endif
      tbl.delete();
      m_ovf = 0;
      m_cnt = 0;
    end
  endfunction

  task automatic send(int id, int x, int y, bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_id    = id[ID_W-1:0];
    in_x     = x[COORD_W-1:0];
    in_y     = y[COORD_W-1:0];
    in_last  = last;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_box(id, x, y, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fin_q.size() != 0 || !in_ready) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + fin_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Consumer: optional random backpressure, or a 5-cycle stall on each new report.
  initial begin
    int  stall_ctr;
    bit  was_v;
    stall_ctr = 0;
    was_v = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_en && out_valid && !was_v) stall_ctr = 5;
      was_v = out_valid;
      if (stall_ctr > 0) begin
        out_ready = 1'b0;
        stall_ctr--;
      end else begin
        out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops expected reports on each handshake and end-of-module status on each done.
  initial begin
    bit pend;
    bit postd;
    int pa;
    int pb;
    rep_t r;
    fin_t f;
    pend = 1'b0;
    postd = 1'b0;
    pa = 0;
    pb = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend  = 1'b0;
        postd = 1'b0;
        continue;
      end
      if (pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_id_a", out_id_a, pa);
        check("hold_id_b", out_id_b, pb);
      end
      if (postd) begin
        check("done_width", done, 0);
        check("overflow_cleared", overflow, 0);
        check("count_cleared", overlap_count, 0);
        postd = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("id_a", out_id_a, r.a);
          check("id_b", out_id_b, r.b);
        end
      end
      pend = out_valid && !out_ready;
      pa = out_id_a;
      pb = out_id_b;
      if (done) begin
        check("reports_drained_at_done", exp_q.size(), 0);
        if (fin_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          f = fin_q.pop_front();
          check("overflow_at_done", overflow, f.ovf);
          check("count_at_done", overlap_count, f.cnt);
        end
        postd = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d errors=%0d", vectors, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int x;
    int y;
    int idc;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_id_a", out_id_a, 0);
    check("rst_id_b", out_id_b, 0);
    check("rst_count", overlap_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready, 1);

    send(1, 0, 0, 0);   send(2, 0, 40, 1);   wait_drain();
    send(1, 0, 0, 0);   send(2, 40, 0, 1);   wait_drain();
    send(1, 0, 0, 0);   send(2, 0, 80, 0);
    send(3, 80, 0, 0);  send(4, 80, 80, 1);  wait_drain();
    stall_en = 1'b1;
    send(1, 0, 0, 0);   send(2, 0, 40, 0);   send(3, 0, 80, 1);  wait_drain();
    stall_en = 1'b0;
    send(1, 0, 0, 0);   send(2, 0, 40, 0);   send(3, 120, 120, 1); wait_drain();
    send(7, 65500, 0, 0); send(8, 10, 0, 0); send(9, 65535, 79, 1); wait_drain();

    for (int i = 0; i < 17; i++) send(10 + i, i * 80, 500, i == 16);
    wait_drain();

    stall_en = 1'b1;
    send(1, 0, 0, 0);
    send(2, 0, 40, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("emit_reached", out_valid, 1);
    #1;
    rst_n = 1'b0;
    tbl.delete();
    exp_q.delete();
    fin_q.delete();
    m_ovf = 0;
    m_cnt = 0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_id_a", out_id_a, 0);
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    send(5, 0, 0, 0);
    send(6, 0, 40, 1);
    wait_drain();

    rnd_en = 1'b1;
    idc = 0;
    for (int m = 0; m < 14; m++) begin
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) begin
        if (m % 3 == 2) begin
          x = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 100) : $urandom_range(65435, 65535);
          y = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 100) : $urandom_range(65435, 65535);
        end else begin
          x = $urandom_range(0, 300);
          y = $urandom_range(0, 300);
        end
        idc = (idc + 1) % 256;
        send(idc, x, y, i == nb - 1);
      end
    end
    wait_drain();
    rnd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
